riscv_if_fetch_buffer: RTL and testbench

// - Instruction-fetch stage directly upstream of the core's if_* parcel bus.
// - Samples the core's next PC and fetches one aligned parcel from instruction memory.
// - Queues the returned parcel with its PC, halfword-valid mask and fault flags.
// - Drives the if_parcel* outputs; honours the core's if_stall and if_flush.

---
 rtl/riscv_if_fetch_buffer.sv | 190 +++++++++++++++++++
 tb/tb_riscv_if_fetch_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_if_fetch_buffer.sv
// riscv_if_fetch_buffer
// Instruction-fetch stage feeding the core's if_* parcel bus. Samples the core's next PC,
// issues a single outstanding aligned parcel read to instruction memory and queues each
// response (data, PC, halfword-valid mask, fault flags) in a small FIFO whose head drives
// the if_parcel* outputs.
//
// Optional feature: define IF_BYPASS_EN to let a response arriving while the FIFO is empty
// drive if_parcel* combinationally in its ack cycle (0-cycle latency). Without it every
// response passes through the FIFO and if_parcel* come from registers only.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   if_nxt_pc             next fetch PC from core
//   if_stall_nxt_pc       1 = if_nxt_pc not accepted this cycle
//   if_stall, if_flush    core stall (hold head parcel) / discard queued and in-flight work
//   if_parcel*            head parcel, its PC, per-halfword valid and fault flags
//   mem_req, mem_adr      instruction memory request and parcel-aligned address
//   mem_ack, mem_err, mem_q  read completion, read error and read data
module riscv_if_fetch_buffer #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned PARCEL_SIZE = 64,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          if_nxt_pc,
    output logic                     if_stall_nxt_pc,
    input  logic                     if_stall,
    input  logic                     if_flush,
    output logic [PARCEL_SIZE-1:0]   if_parcel,
    output logic [XLEN-1:0]          if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
    output logic                     if_parcel_misaligned,
    output logic                     if_parcel_page_fault,
    output logic                     mem_req,
    output logic [XLEN-1:0]          mem_adr,
    input  logic                     mem_ack,
    input  logic                     mem_err,
    input  logic [PARCEL_SIZE-1:0]   mem_q
);

    localparam int unsigned PB   = PARCEL_SIZE / 8;
    localparam int unsigned HW   = PARCEL_SIZE / 16;
    localparam int unsigned AW   = $clog2(PB);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CW   = PTRW + 1;
    localparam int unsigned CW1  = CW + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDrop} state_e;

    typedef struct packed {
        logic [PARCEL_SIZE-1:0] data;
        logic [XLEN-1:0]        pc;
        logic [HW-1:0]          mask;
        logic                   misaligned;
        logic                   page_fault;
    } entry_t;

    state_e          state;
    logic            mis_pend;   // misaligned PC accepted last cycle, pushed this cycle
    logic [XLEN-1:0] pc_q;       // PC of the outstanding request / pending misaligned entry

    entry_t          fifo [DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic            resp, busy, empty, accept;
    logic            push, pop, push_ack, push_mis, bypass_show, bypass_take;
    logic [CW1-1:0]  credit;
    logic [AW-1:0]   ack_off;
    logic [XLEN-1:0] nxt_adr;
    entry_t          ack_entry, push_entry, out_entry;

    always_comb begin
        resp    = mem_ack | mem_err;
        busy    = (state == StBusy);
        empty   = (count == '0);
        nxt_adr = if_nxt_pc & ~XLEN'(PB - 1);
        // Slots already promised: queued entries, the in-flight read and a pending misaligned push.
        credit  = {1'b0, count} + CW1'(busy) + CW1'(mis_pend);
        if_stall_nxt_pc = rst | if_flush | (state == StDrop) | (busy & ~resp) |
                          (credit >= CW1'(DEPTH));
        accept  = ~if_stall_nxt_pc;

        ack_off            = pc_q[AW-1:0] >> 1;
        ack_entry.data     = mem_err ? '0 : mem_q;
        ack_entry.pc       = pc_q;
        for (int unsigned i = 0; i < HW; i++) begin
            ack_entry.mask[i] = mem_err | (i >= 32'(ack_off));
        end
        ack_entry.misaligned = 1'b0;
        ack_entry.page_fault = mem_err;

`ifdef IF_BYPASS_EN
        bypass_show = empty & busy & resp & ~if_flush;
`else
        bypass_show = 1'b0;
`endif
        bypass_take = bypass_show & ~if_stall;
        push_ack    = busy & resp & ~if_flush & ~bypass_take;
        push_mis    = mis_pend & ~if_flush;
        push        = push_ack | push_mis;
        pop         = ~if_stall & ~empty & ~if_flush;

        if (push_mis) begin
            push_entry.data       = '0;
            push_entry.pc         = pc_q;
            push_entry.mask       = '1;
            push_entry.misaligned = 1'b1;
            push_entry.page_fault = 1'b0;
        end else begin
            push_entry = ack_entry;
        end

        if (bypass_show) begin
            out_entry = ack_entry;
        end else if (!empty) begin
            out_entry = fifo[rd_ptr];
        end else begin
            out_entry = '0;
        end
        if_parcel            = out_entry.data;
        if_parcel_pc         = out_entry.pc;
        if_parcel_valid      = out_entry.mask;
        if_parcel_misaligned = out_entry.misaligned;
        if_parcel_page_fault = out_entry.page_fault;
    end

    // Request FSM with registered memory interface.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            mem_req  <= 1'b0;
            mem_adr  <= '0;
            mis_pend <= 1'b0;
            pc_q     <= '0;
        end else begin
            mis_pend <= accept & if_nxt_pc[0];
            if (accept) pc_q <= if_nxt_pc;
            unique case (state)
                StIdle: begin
                    if (accept && !if_nxt_pc[0]) begin
                        state   <= StBusy;
                        mem_req <= 1'b1;
                        mem_adr <= nxt_adr;
                    end
                end
                StBusy: begin
                    if (resp) begin
                        // Back-to-back fetch: a new aligned PC keeps the request up.
                        if (accept && !if_nxt_pc[0]) begin
                            mem_adr <= nxt_adr;
                        end else begin
                            state   <= StIdle;
                            mem_req <= 1'b0;
                        end
                    end else if (if_flush) begin
                        state <= StDrop;
                    end
                end
                StDrop: begin
                    if (resp) begin
                        state   <= StIdle;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // FIFO control; flush takes priority over push and pop.
    always_ff @(posedge clk) begin
        if (rst || if_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= push_entry;
    end

endmodule

// File: tb/tb_riscv_if_fetch_buffer.sv
// Directed bench for riscv_if_fetch_buffer (XLEN=64, PARCEL_SIZE=64, DEPTH=4, no bypass).
// Inputs change 1 time unit after each rising edge; outputs are sampled on the falling edge.
module tb_riscv_if_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] if_nxt_pc;
    logic        if_stall_nxt_pc;
    logic        if_stall;
    logic        if_flush;
    logic [63:0] if_parcel;
    logic [63:0] if_parcel_pc;
    logic [3:0]  if_parcel_valid;
    logic        if_parcel_misaligned;
    logic        if_parcel_page_fault;
    logic        mem_req;
    logic [63:0] mem_adr;
    logic        mem_ack;
    logic        mem_err;
    logic [63:0] mem_q;

    int checks = 0;
    int errors = 0;

    riscv_if_fetch_buffer #(
        .XLEN        (64),
        .PARCEL_SIZE (64),
        .DEPTH       (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .if_nxt_pc            (if_nxt_pc),
        .if_stall_nxt_pc      (if_stall_nxt_pc),
        .if_stall             (if_stall),
        .if_flush             (if_flush),
        .if_parcel            (if_parcel),
        .if_parcel_pc         (if_parcel_pc),
        .if_parcel_valid      (if_parcel_valid),
        .if_parcel_misaligned (if_parcel_misaligned),
        .if_parcel_page_fault (if_parcel_page_fault),
        .mem_req              (mem_req),
        .mem_adr              (mem_adr),
        .mem_ack              (mem_ack),
        .mem_err              (mem_err),
        .mem_q                (mem_q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_nxt_pc = '0; if_stall = 1'b0; if_flush = 1'b0;
        mem_ack = 1'b0; mem_err = 1'b0; mem_q = '0;

        // Reset
        tick(); tick();
        @(negedge clk);
        check("rst_stall_nxt", 64'(if_stall_nxt_pc), 64'd1);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_adr", mem_adr, 64'd0);
        check("rst_valid", 64'(if_parcel_valid), 64'd0);
        check("rst_parcel", if_parcel, 64'd0);
        check("rst_parcel_pc", if_parcel_pc, 64'd0);

        // A: offer 0x200
        tick(); rst = 1'b0; if_nxt_pc = 64'h200;
        @(negedge clk);
        check("A_stall_nxt", 64'(if_stall_nxt_pc), 64'd0);

        // B: request out, ack it, offer 0x206
        tick(); mem_ack = 1'b1; mem_q = 64'h1122334455667788; if_nxt_pc = 64'h206;
        @(negedge clk);
        check("B_mem_req", 64'(mem_req), 64'd1);
        check("B_mem_adr", mem_adr, 64'h200);
        check("B_valid_empty", 64'(if_parcel_valid), 64'd0);

        // C: first parcel one cycle after ack
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check("C_parcel", if_parcel, 64'h1122334455667788);
        check("C_parcel_pc", if_parcel_pc, 64'h200);
        check("C_valid", 64'(if_parcel_valid), 64'hf);
        check("C_stall_nxt", 64'(if_stall_nxt_pc), 64'd1);
        check("C_mem_adr_206", mem_adr, 64'h200);
        check("C_mem_req", 64'(mem_req), 64'd1);

        // D: ack 0x206 fetch, offer misaligned 0x201
        tick(); mem_ack = 1'b1; mem_q = 64'hAAAABBBBCCCCDDDD; if_nxt_pc = 64'h201;
        @(negedge clk);
        check("D_valid_popped", 64'(if_parcel_valid), 64'd0);

        // E: 0x206 parcel; no request for 0x201; offer 0x300
        tick(); mem_ack = 1'b0; if_nxt_pc = 64'h300;
        @(negedge clk);
        check("E_valid_206", 64'(if_parcel_valid), 64'h8);
        check("E_parcel_pc", if_parcel_pc, 64'h206);
        check("E_parcel", if_parcel, 64'hAAAABBBBCCCCDDDD);
        check("E_mem_req_mis", 64'(mem_req), 64'd0);
        check("E_stall_nxt", 64'(if_stall_nxt_pc), 64'd0);

        // F: misaligned entry at head; error response for 0x300; offer 0x200
        tick(); mem_err = 1'b1; mem_q = 64'hDEADBEEFDEADBEEF; if_nxt_pc = 64'h200;
        @(negedge clk);
        check("F_misaligned", 64'(if_parcel_misaligned), 64'd1);
        check("F_mis_valid", 64'(if_parcel_valid), 64'hf);
        check("F_mis_parcel", if_parcel, 64'd0);
        check("F_mis_pc", if_parcel_pc, 64'h201);
        check("F_mem_req", 64'(mem_req), 64'd1);
        check("F_mem_adr", mem_adr, 64'h300);

        // G: faulted entry at head; ack 0x200; offer 0x208
        tick(); mem_err = 1'b0; mem_ack = 1'b1; mem_q = 64'hCAFE000000000200;
        if_nxt_pc = 64'h208;
        @(negedge clk);
        check("G_page_fault", 64'(if_parcel_page_fault), 64'd1);
        check("G_pf_parcel", if_parcel, 64'd0);
        check("G_pf_pc", if_parcel_pc, 64'h300);
        check("G_pf_valid", 64'(if_parcel_valid), 64'hf);
        check("G_pf_misaligned", 64'(if_parcel_misaligned), 64'd0);

        // H..J: core stalls while three more acks fill the FIFO
        tick(); if_stall = 1'b1; mem_q = 64'hCAFE000000000208; if_nxt_pc = 64'h210;
        @(negedge clk);
        check("H_mem_adr", mem_adr, 64'h208);
        tick(); mem_q = 64'hCAFE000000000210; if_nxt_pc = 64'h218;
        @(negedge clk);
        check("I_mem_adr", mem_adr, 64'h210);
        check("I_stall_nxt", 64'(if_stall_nxt_pc), 64'd0);
        tick(); mem_q = 64'hCAFE000000000218; if_nxt_pc = 64'h220;
        @(negedge clk);
        check("J_mem_adr", mem_adr, 64'h218);
        check("J_stall_nxt_full", 64'(if_stall_nxt_pc), 64'd1);

        // K, L: full FIFO, no fifth request
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check("K_stall_nxt", 64'(if_stall_nxt_pc), 64'd1);
        check("K_mem_req", 64'(mem_req), 64'd0);
        check("K_head_pc", if_parcel_pc, 64'h200);
        tick();
        @(negedge clk);
        check("L_mem_req", 64'(mem_req), 64'd0);
        check("L_head_pc", if_parcel_pc, 64'h200);

        // M..O: release stall, parcels drain in PC order
        tick(); if_stall = 1'b0;
        @(negedge clk);
        check("M_pc", if_parcel_pc, 64'h200);
        check("M_parcel", if_parcel, 64'hCAFE000000000200);
        tick();
        @(negedge clk);
        check("N_pc", if_parcel_pc, 64'h208);
        check("N_parcel", if_parcel, 64'hCAFE000000000208);
        tick();
        @(negedge clk);
        check("O_pc", if_parcel_pc, 64'h210);
        check("O_mem_req", 64'(mem_req), 64'd1);
        check("O_mem_adr", mem_adr, 64'h220);

        // P: flush while BUSY with 0x218 still queued
        tick(); if_stall = 1'b1; if_flush = 1'b1;
        @(negedge clk);
        check("P_pc", if_parcel_pc, 64'h218);
        check("P_stall_nxt", 64'(if_stall_nxt_pc), 64'd1);

        // Q: FIFO empty, request still outstanding
        tick(); if_flush = 1'b0; if_stall = 1'b0; if_nxt_pc = 64'h400;
        @(negedge clk);
        check("Q_valid", 64'(if_parcel_valid), 64'd0);
        check("Q_stall_nxt", 64'(if_stall_nxt_pc), 64'd1);
        check("Q_mem_req", 64'(mem_req), 64'd1);
        check("Q_mem_adr", mem_adr, 64'h220);

        // R: dropped ack
        tick(); mem_ack = 1'b1; mem_q = 64'h0BAD0BAD0BAD0BAD;
        @(negedge clk);
        check("R_stall_nxt", 64'(if_stall_nxt_pc), 64'd1);

        // S: dropped data never shows; 0x400 accepted
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check("S_valid", 64'(if_parcel_valid), 64'd0);
        check("S_mem_req", 64'(mem_req), 64'd0);
        check("S_stall_nxt", 64'(if_stall_nxt_pc), 64'd0);

        // T: fetch 0x400 normally; offer 0x408
        tick(); mem_ack = 1'b1; mem_q = 64'h4444444444444444; if_nxt_pc = 64'h408;
        @(negedge clk);
        check("T_mem_req", 64'(mem_req), 64'd1);
        check("T_mem_adr", mem_adr, 64'h400);

        // U: 0x400 parcel; reset with 0x408 in flight
        tick(); mem_ack = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("U_parcel", if_parcel, 64'h4444444444444444);
        check("U_pc", if_parcel_pc, 64'h400);
        check("U_valid", 64'(if_parcel_valid), 64'hf);
        check("U_stall_nxt_rst", 64'(if_stall_nxt_pc), 64'd1);

        // V: request dropped by reset; stray ack in IDLE
        tick(); rst = 1'b0; mem_ack = 1'b1; mem_q = 64'h5555555555555555;
        @(negedge clk);
        check("V_mem_req", 64'(mem_req), 64'd0);
        check("V_mem_adr", mem_adr, 64'd0);
        check("V_valid", 64'(if_parcel_valid), 64'd0);

        // W: stray ack ignored; new fetch of 0x408 proceeds
        tick(); mem_ack = 1'b0;
        @(negedge clk);
        check("W_valid", 64'(if_parcel_valid), 64'd0);
        check("W_mem_req", 64'(mem_req), 64'd1);
        check("W_mem_adr", mem_adr, 64'h408);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
